axil_cfg_master: RTL and testbench

AXI-Lite initiator that converts single-beat register commands into AXI-Lite write (AW+W) or read (AR+R) transactions toward the fir configuration slave (ap_ctrl, data_length, tap coefficients). It replaces hand-driven bench/firmware pin wiggling with a command/response handshake. The block sits between a control sequencer (bench or CPU-side bridge) and the fir AXI-Lite port. The fir interface has no B channel, so a write completes on the AW and W handshakes.

---
 rtl/axil_cfg_master.sv | 259 +++++++++++++++++++++++++
 tb/tb_axil_cfg_master.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/axil_cfg_master.sv
`default_nettype none
// ============================================================================
// Module      : axil_cfg_master
// Description : AXI-Lite initiator for the fir configuration slave. Converts
//               single-beat register commands (cmd_*) into one AXI-Lite write
//               (AW+W, no B channel) or read (AR+R) and returns a single
//               response (rsp_*). One transaction outstanding at a time.
// Ports       : axis_clk/axis_rst   clock, synchronous active-high reset
//               cmd_*               command request/accept handshake
//               rsp_*               response handshake (rdata, type, error)
//               aw*/w*/ar*/r*       AXI-Lite master channels toward the fir
// Option      : define AXIL_CFG_TIMEOUT_EN to abort a channel that waits
//               TIMEOUT_CYCLES cycles; the response then carries rsp_err=1.
// Revision    : 1.0 - initial release
// ============================================================================
module axil_cfg_master #(
  parameter int pADDR_WIDTH    = 12,
  parameter int pDATA_WIDTH    = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                   axis_clk,
  input  logic                   axis_rst,
  // command side
  input  logic                   cmd_valid,
  output logic                   cmd_ready,
  input  logic                   cmd_write,
  input  logic [pADDR_WIDTH-1:0] cmd_addr,
  input  logic [pDATA_WIDTH-1:0] cmd_wdata,
  // response side
  output logic                   rsp_valid,
  input  logic                   rsp_ready,
  output logic                   rsp_write,
  output logic [pDATA_WIDTH-1:0] rsp_rdata,
  output logic                   rsp_err,
  // AXI-Lite write address / data
  output logic                   awvalid,
  output logic [pADDR_WIDTH-1:0] awaddr,
  input  logic                   awready,
  output logic                   wvalid,
  output logic [pDATA_WIDTH-1:0] wdata,
  input  logic                   wready,
  // AXI-Lite read address / data
  output logic                   arvalid,
  output logic [pADDR_WIDTH-1:0] araddr,
  input  logic                   arready,
  input  logic                   rvalid,
  input  logic [pDATA_WIDTH-1:0] rdata,
  output logic                   rready
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_WRITE   = 3'd1,
    S_RD_ADDR = 3'd2,
    S_RD_DATA = 3'd3,
    S_RESP    = 3'd4
  } state_e;

  state_e                 state_q,     state_d;
  logic                   awvalid_q,   awvalid_d;
  logic                   wvalid_q,    wvalid_d;
  logic                   aw_done_q,   aw_done_d;
  logic                   w_done_q,    w_done_d;
  logic                   arvalid_q,   arvalid_d;
  logic                   rready_q,    rready_d;
  logic                   rsp_valid_q, rsp_valid_d;
  logic                   rsp_write_q, rsp_write_d;
  logic                   rsp_err_q,   rsp_err_d;
  logic [pADDR_WIDTH-1:0] awaddr_q,    awaddr_d;
  logic [pADDR_WIDTH-1:0] araddr_q,    araddr_d;
  logic [pDATA_WIDTH-1:0] wdata_q,     wdata_d;
  logic [pDATA_WIDTH-1:0] rsp_rdata_q, rsp_rdata_d;

  logic w_cmd_hs;
  logic w_aw_hs;
  logic w_w_hs;
  logic w_ar_hs;
  logic w_r_hs;

`ifdef AXIL_CFG_TIMEOUT_EN
  // At least 8 bits, wider if the limit needs it.
  localparam int c_CNT_W = ($clog2(TIMEOUT_CYCLES + 1) > 8) ? $clog2(TIMEOUT_CYCLES + 1) : 8;
  localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(TIMEOUT_CYCLES - 1);

  logic [c_CNT_W-1:0] cnt_q, cnt_d;
  logic               w_busy;
`else
  logic w_unused_timeout;
  assign w_unused_timeout = |TIMEOUT_CYCLES;
`endif

  assign w_cmd_hs = cmd_valid & (state_q == S_IDLE);
  assign w_aw_hs  = awvalid_q & awready;
  assign w_w_hs   = wvalid_q & wready;
  assign w_ar_hs  = arvalid_q & arready;
  assign w_r_hs   = rready_q & rvalid;

  always_comb begin
    state_d     = state_q;
    awvalid_d   = awvalid_q;
    wvalid_d    = wvalid_q;
    aw_done_d   = aw_done_q;
    w_done_d    = w_done_q;
    arvalid_d   = arvalid_q;
    rready_d    = rready_q;
    rsp_valid_d = rsp_valid_q;
    rsp_write_d = rsp_write_q;
    rsp_err_d   = rsp_err_q;
    awaddr_d    = awaddr_q;
    araddr_d    = araddr_q;
    wdata_d     = wdata_q;
    rsp_rdata_d = rsp_rdata_q;

    case (state_q)
      S_IDLE: begin
        if (w_cmd_hs) begin
          rsp_err_d   = 1'b0;
          rsp_write_d = cmd_write;
          rsp_rdata_d = '0;
          if (cmd_write) begin
            awaddr_d  = cmd_addr;
            wdata_d   = cmd_wdata;
            awvalid_d = 1'b1;
            wvalid_d  = 1'b1;
            aw_done_d = 1'b0;
            w_done_d  = 1'b0;
            state_d   = S_WRITE;
          end else begin
            araddr_d  = cmd_addr;
            arvalid_d = 1'b1;
            state_d   = S_RD_ADDR;
          end
        end
      end

      S_WRITE: begin
        // AW and W complete independently; either may finish first.
        if (w_aw_hs) begin
          awvalid_d = 1'b0;
          aw_done_d = 1'b1;
        end
        if (w_w_hs) begin
          wvalid_d = 1'b0;
          w_done_d = 1'b1;
        end
        if ((aw_done_q | w_aw_hs) & (w_done_q | w_w_hs)) begin
          rsp_valid_d = 1'b1;
          state_d     = S_RESP;
        end
      end

      S_RD_ADDR: begin
        // rvalid in this state is ignored; the slave must hold it.
        if (w_ar_hs) begin
          arvalid_d = 1'b0;
          rready_d  = 1'b1;
          state_d   = S_RD_DATA;
        end
      end

      S_RD_DATA: begin
        if (w_r_hs) begin
          rsp_rdata_d = rdata;
          rready_d    = 1'b0;
          rsp_valid_d = 1'b1;
          state_d     = S_RESP;
        end
      end

      S_RESP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = S_IDLE;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

`ifdef AXIL_CFG_TIMEOUT_EN
    w_busy = (state_q == S_WRITE) | (state_q == S_RD_ADDR) | (state_q == S_RD_DATA);
    // Abort only when this cycle makes no progress out of the busy state.
    if (w_busy && (state_d == state_q) && (cnt_q == c_CNT_LAST)) begin
      awvalid_d   = 1'b0;
      wvalid_d    = 1'b0;
      arvalid_d   = 1'b0;
      rready_d    = 1'b0;
      rsp_valid_d = 1'b1;
      rsp_err_d   = 1'b1;
      rsp_rdata_d = '0;
      state_d     = S_RESP;
    end
    if (state_d != state_q) begin
      cnt_d = '0;
    end else if (w_busy) begin
      cnt_d = cnt_q + c_CNT_W'(1);
    end else begin
      cnt_d = cnt_q;
    end
`endif
  end

  always_ff @(posedge axis_clk) begin
    if (axis_rst) begin
      state_q     <= S_IDLE;
      awvalid_q   <= 1'b0;
      wvalid_q    <= 1'b0;
      aw_done_q   <= 1'b0;
      w_done_q    <= 1'b0;
      arvalid_q   <= 1'b0;
      rready_q    <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_write_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      awaddr_q    <= '0;
      araddr_q    <= '0;
      wdata_q     <= '0;
      rsp_rdata_q <= '0;
`ifdef AXIL_CFG_TIMEOUT_EN
      cnt_q       <= '0;
`endif
    end else begin
      state_q     <= state_d;
      awvalid_q   <= awvalid_d;
      wvalid_q    <= wvalid_d;
      aw_done_q   <= aw_done_d;
      w_done_q    <= w_done_d;
      arvalid_q   <= arvalid_d;
      rready_q    <= rready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_write_q <= rsp_write_d;
      rsp_err_q   <= rsp_err_d;
      awaddr_q    <= awaddr_d;
      araddr_q    <= araddr_d;
      wdata_q     <= wdata_d;
      rsp_rdata_q <= rsp_rdata_d;
`ifdef AXIL_CFG_TIMEOUT_EN
      cnt_q       <= cnt_d;
`endif
    end
  end

  assign cmd_ready = (state_q == S_IDLE);
  assign rsp_valid = rsp_valid_q;
  assign rsp_write = rsp_write_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;
  assign awvalid   = awvalid_q;
  assign awaddr    = awaddr_q;
  assign wvalid    = wvalid_q;
  assign wdata     = wdata_q;
  assign arvalid   = arvalid_q;
  assign araddr    = araddr_q;
  assign rready    = rready_q;

endmodule
`default_nettype wire

// File: tb/tb_axil_cfg_master.sv
`default_nettype none
// ============================================================================
// Module      : tb_axil_cfg_master
// Description : Self-checking bench for axil_cfg_master. A table of command
//               vectors drives the master while the bench plays the AXI-Lite
//               slave with per-vector wait states; expected responses go to a
//               scoreboard queue at command issue and are popped on rsp
//               handshake. Hand-written sequences cover reset mid-write.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_axil_cfg_master;

  localparam int AW = 12;
  localparam int DW = 32;
`ifdef AXIL_CFG_TIMEOUT_EN
  localparam int TO = 8;
`else
  localparam int TO = 255;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          cmd_valid = 1'b0, cmd_write = 1'b0;
  logic [AW-1:0] cmd_addr = '0;
  logic [DW-1:0] cmd_wdata = '0;
  logic          cmd_ready;
  logic          rsp_valid, rsp_write, rsp_err;
  logic [DW-1:0] rsp_rdata;
  logic          rsp_ready = 1'b0;
  logic          awvalid, wvalid, arvalid, rready;
  logic [AW-1:0] awaddr, araddr;
  logic [DW-1:0] wdata;
  logic          awready = 1'b0, wready = 1'b0, arready = 1'b0, rvalid = 1'b0;
  logic [DW-1:0] rdata = '0;

  axil_cfg_master #(
    .pADDR_WIDTH(AW), .pDATA_WIDTH(DW), .TIMEOUT_CYCLES(TO)
  ) dut (
    .axis_clk(clk), .axis_rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_write(rsp_write),
    .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .awvalid(awvalid), .awaddr(awaddr), .awready(awready),
    .wvalid(wvalid), .wdata(wdata), .wready(wready),
    .arvalid(arvalid), .araddr(araddr), .arready(arready),
    .rvalid(rvalid), .rdata(rdata), .rready(rready)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          wr;
    logic [11:0] addr;
    logic [31:0] wdata;
    int          daw, dw, dar, dr;  // slave wait cycles per channel
    logic [31:0] rdata;             // data the slave returns
    int          hold;              // cycles rsp_ready is held low
    int          lat;               // expected first rsp_valid sample after cmd edge
    int          aw_hi, w_hi, ar_hi, rr_hi;
    logic [31:0] exp_rdata;
    bit          exp_err;
  } vec_t;

  typedef struct {
    bit          wr;
    logic [31:0] rdata;
    bit          err;
  } exp_rsp_t;

  exp_rsp_t sbq[$];
  vec_t     tbl[$];
  int       n_cmp  = 0;
  int       n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic vec_t mk(bit wr, logic [11:0] addr, logic [31:0] wd,
                              int daw, int dw, int dar, int dr,
                              logic [31:0] rd, int hold, int lat,
                              int aw_hi, int w_hi, int ar_hi, int rr_hi,
                              logic [31:0] exp_rd, bit exp_err);
    vec_t v;
    v.wr = wr; v.addr = addr; v.wdata = wd;
    v.daw = daw; v.dw = dw; v.dar = dar; v.dr = dr;
    v.rdata = rd; v.hold = hold; v.lat = lat;
    v.aw_hi = aw_hi; v.w_hi = w_hi; v.ar_hi = ar_hi; v.rr_hi = rr_hi;
    v.exp_rdata = exp_rd; v.exp_err = exp_err;
    return v;
  endfunction

  // Issue one command and act as the slave/response consumer until the
  // response handshake; every sample is taken 1 time unit after posedge.
  task automatic run_vec(input vec_t v, input int idx);
    int t, guard, aw_seen, w_seen, ar_seen, ar_hs_t, rsp_t0, held;
    int aw_hi, w_hi, ar_hi, rr_hi;
    bit done, r_done;
    logic [31:0] rd0;
    exp_rsp_t e, g;
    string tag;
    tag = $sformatf("v%0d", idx);
    guard = 0;
    while (!cmd_ready && guard < 50) begin tick(); guard++; end
    chk({tag, "_cmd_ready_idle"}, {31'd0, cmd_ready}, 32'd1);
    cmd_valid = 1'b1; cmd_write = v.wr; cmd_addr = v.addr; cmd_wdata = v.wdata;
    e.wr = v.wr; e.rdata = v.exp_rdata; e.err = v.exp_err;
    sbq.push_back(e);
    tick();
    cmd_valid = 1'b0;
    t = 1; aw_seen = 0; w_seen = 0; ar_seen = 0; ar_hs_t = -1; rsp_t0 = -1; held = 0;
    aw_hi = 0; w_hi = 0; ar_hi = 0; rr_hi = 0; done = 0; r_done = 0; rd0 = '0;
    while (!done && t < 400) begin
      if (t == 1) begin
        chk({tag, "_cmd_ready_busy"}, {31'd0, cmd_ready}, 32'd0);
        chk({tag, "_rsp_err_cleared"}, {31'd0, rsp_err}, 32'd0);
      end
      awready = 1'b0;
      if (awvalid) begin
        aw_hi++;
        chk({tag, "_awaddr"}, {20'd0, awaddr}, {20'd0, v.addr});
        awready = (aw_seen == v.daw);
        aw_seen++;
      end
      wready = 1'b0;
      if (wvalid) begin
        w_hi++;
        chk({tag, "_wdata"}, wdata, v.wdata);
        wready = (w_seen == v.dw);
        w_seen++;
      end
      arready = 1'b0;
      if (arvalid) begin
        ar_hi++;
        chk({tag, "_araddr"}, {20'd0, araddr}, {20'd0, v.addr});
        arready = (ar_seen == v.dar);
        if (arready) ar_hs_t = t;
        ar_seen++;
      end
      if (rready) rr_hi++;
      if (ar_hs_t >= 0 && t >= ar_hs_t + 1 + v.dr && !r_done) begin
        rvalid = 1'b1; rdata = v.rdata;
        if (rready) r_done = 1;
      end else begin
        rvalid = 1'b0; rdata = '0;
      end
      rsp_ready = 1'b0;
      if (rsp_valid) begin
        if (rsp_t0 < 0) begin
          rsp_t0 = t; rd0 = rsp_rdata;
          chk({tag, "_latency"}, t, v.lat);
        end else begin
          chk({tag, "_rdata_stable"}, rsp_rdata, rd0);
        end
        if (held >= v.hold) begin
          rsp_ready = 1'b1;
          if (sbq.size() == 0) begin
            chk({tag, "_sb_nonempty"}, 32'd0, 32'd1);
          end else begin
            e = sbq.pop_front();
            g.wr = rsp_write; g.rdata = rsp_rdata; g.err = rsp_err;
            chk({tag, "_rsp_write"}, {31'd0, g.wr}, {31'd0, e.wr});
            chk({tag, "_rsp_rdata"}, g.rdata, e.rdata);
            chk({tag, "_rsp_err"}, {31'd0, g.err}, {31'd0, e.err});
          end
          done = 1;
        end else begin
          chk({tag, "_cmd_ready_hold"}, {31'd0, cmd_ready}, 32'd0);
          held++;
        end
      end
      tick();
      t++;
    end
    if (!done) chk({tag, "_rsp_timeout"}, 32'd0, 32'd1);
    awready = 1'b0; wready = 1'b0; arready = 1'b0; rvalid = 1'b0; rsp_ready = 1'b0;
    chk({tag, "_rsp_valid_drop"}, {31'd0, rsp_valid}, 32'd0);
    chk({tag, "_cmd_ready_after"}, {31'd0, cmd_ready}, 32'd1);
    chk({tag, "_aw_hi"}, aw_hi, v.aw_hi);
    chk({tag, "_w_hi"}, w_hi, v.w_hi);
    chk({tag, "_ar_hi"}, ar_hi, v.ar_hi);
    chk({tag, "_rr_hi"}, rr_hi, v.rr_hi);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    //             wr addr    wdata         daw dw dar dr rdata        hold lat aw w ar rr exp_rd       err
    tbl.push_back(mk(1, 12'h010, 32'h0000_0037, 0, 0, 0, 0, 32'h0,        0, 2, 1, 1, 0, 0, 32'h0,        0));
    tbl.push_back(mk(1, 12'h040, 32'hFFFF_FFF6, 3, 0, 0, 0, 32'h0,        0, 5, 4, 1, 0, 0, 32'h0,        0));
    tbl.push_back(mk(0, 12'h000, 32'h0,         0, 0, 2, 1, 32'h0000_0004, 0, 6, 0, 0, 3, 2, 32'h0000_0004, 0));
    tbl.push_back(mk(0, 12'h024, 32'h0,         0, 0, 0, 0, 32'hDEAD_BEEF, 5, 3, 0, 0, 1, 1, 32'hDEAD_BEEF, 0));
    tbl.push_back(mk(1, 12'h028, 32'h1234_5678, 0, 2, 0, 0, 32'h0,        0, 4, 1, 3, 0, 0, 32'h0,        0));
    tbl.push_back(mk(1, 12'h02C, 32'hA5A5_A5A5, 2, 2, 0, 0, 32'h0,        0, 4, 3, 3, 0, 0, 32'h0,        0));
    tbl.push_back(mk(1, 12'h080, 32'h0000_0001, 1, 3, 0, 0, 32'h0,        2, 5, 2, 4, 0, 0, 32'h0,        0));
`ifdef AXIL_CFG_TIMEOUT_EN
    // arready never comes: arvalid held for TO cycles, then error response.
    tbl.push_back(mk(0, 12'h030, 32'h0,         0, 0, 999, 0, 32'h5555_5555, 0, 9, 0, 0, 8, 0, 32'h0,     1));
    tbl.push_back(mk(0, 12'h034, 32'h0,         0, 0, 0, 0, 32'h0000_00AB, 0, 3, 0, 0, 1, 1, 32'h0000_00AB, 0));
`endif

    // Reset state.
    tick(); tick();
    chk("rst_cmd_ready", {31'd0, cmd_ready}, 32'd1);
    chk("rst_valids", {28'd0, awvalid, wvalid, arvalid, rready}, 32'd0);
    chk("rst_rsp", {29'd0, rsp_valid, rsp_write, rsp_err}, 32'd0);
    chk("rst_rsp_rdata", rsp_rdata, 32'd0);
    chk("rst_addr", {8'd0, awaddr, araddr}, 32'd0);
    chk("rst_wdata", wdata, 32'd0);
    rst = 1'b0;
    tick();

    for (int i = 0; i < tbl.size(); i++) run_vec(tbl[i], i);

    // Reset pulsed while a write is stalled on awready/wready.
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 12'h050; cmd_wdata = 32'hCAFE_0001;
    tick();
    cmd_valid = 1'b0;
    tick();
    chk("mid_awvalid_pre", {31'd0, awvalid}, 32'd1);
    chk("mid_wvalid_pre", {31'd0, wvalid}, 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("mid_valids_post", {28'd0, awvalid, wvalid, arvalid, rready}, 32'd0);
    chk("mid_cmd_ready_post", {31'd0, cmd_ready}, 32'd1);
    chk("mid_rsp_valid_post", {31'd0, rsp_valid}, 32'd0);
    tick();
    chk("mid_no_resp", {31'd0, rsp_valid}, 32'd0);

    run_vec(mk(1, 12'h054, 32'h0BAD_F00D, 1, 0, 0, 0, 32'h0, 0, 3, 2, 1, 0, 0, 32'h0, 0), 100);

    chk("sb_empty", sbq.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
